// File: rtl/csr_timer.sv
// csr_timer: prescaled compare timer exposed as four custom machine CSRs.
//
// It answers the core's external CSR port with no internal memory, and it drives
// the core's level-sensitive irq_timer input.
//
// Register window (offset from BASE_ADDR):
//   +0 CTRL     bit0 EN, bit1 IE, bit2 AUTO_RELOAD, bit3 PEND (write 1 to clear)
//   +1 COUNT    32-bit counter, read/write
//   +2 CMP      32-bit compare value, read/write
//   +3 PRESCALE PRESCALE_WIDTH-bit tick divider, read/write
//
// Ports:
//   clock      system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   csr_read   read request, one-cycle pulse
//   csr_write  write request, one-cycle pulse
//   csr_addr   CSR number
//   csr_wdata  final write value
//   csr_rdata  pre-write value of the addressed register, one cycle after a hit
//   csr_valid  address hit, one cycle after the request
//   irq_timer  PEND & IE, driven from a register
module csr_timer #(
  parameter logic [11:0] BASE_ADDR      = 12'hBC0,
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] RESET_CMP      = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_valid,
  output logic        irq_timer
);

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_COUNT = 2'd1;
  localparam logic [1:0] OFF_CMP   = 2'd2;
  localparam logic [1:0] OFF_PSC   = 2'd3;

  logic                      en_q, en_d;
  logic                      ie_q, ie_d;
  logic                      auto_q, auto_d;
  logic                      pend_q, pend_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               cmp_q, cmp_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      valid_q, valid_d;
  logic                      irq_q, irq_d;

  logic        win_s, hit_s, wr_s;
  logic        wr_ctrl_s, wr_count_s, wr_cmp_s, wr_psc_s;
  logic        tick_s, match_s;
  logic [31:0] rd_mux_s, psc_rd_s;

  // Address decode, prescaler tick and compare detection.
  always_comb begin
    // Every decode term is gated by the request strobes, so an X address on an
    // idle cycle cannot leak into any state.
    win_s      = (csr_addr[11:2] == BASE_ADDR[11:2]);
    hit_s      = (csr_read | csr_write) & win_s;
    wr_s       = csr_write & win_s;
    wr_ctrl_s  = wr_s & (csr_addr[1:0] == OFF_CTRL);
    wr_count_s = wr_s & (csr_addr[1:0] == OFF_COUNT);
    wr_cmp_s   = wr_s & (csr_addr[1:0] == OFF_CMP);
    wr_psc_s   = wr_s & (csr_addr[1:0] == OFF_PSC);
    tick_s     = en_q & (psc_q == prescale_q);
    match_s    = tick_s & (count_q == cmp_q);
  end

  // Read mux: returns register values as they are before this cycle's write.
  always_comb begin
    psc_rd_s                      = 32'd0;
    psc_rd_s[PRESCALE_WIDTH-1:0]  = prescale_q;
    rd_mux_s                      = 32'd0;
    case (csr_addr[1:0])
      OFF_CTRL:  rd_mux_s = {28'd0, pend_q, auto_q, ie_q, en_q};
      OFF_COUNT: rd_mux_s = count_q;
      OFF_CMP:   rd_mux_s = cmp_q;
      OFF_PSC:   rd_mux_s = psc_rd_s;
      default:   rd_mux_s = 32'd0;
    endcase
  end

  // Next-state logic for the timer registers and the response stage.
  always_comb begin
    // Prescaler: it runs only while EN is set and wraps at PRESCALE. Any write
    // that changes the timebase (CTRL, COUNT, PRESCALE) restarts it from zero.
    if (wr_ctrl_s | wr_count_s | wr_psc_s) begin
      psc_d = '0;
    end else if (!en_q || tick_s) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PRESCALE_WIDTH'(1);
    end

    // COUNT: a CSR write beats the tick increment.
    if (wr_count_s) begin
      count_d = csr_wdata;
    end else if (match_s && auto_q) begin
      count_d = 32'd0;
    end else if (tick_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    // PEND: a compare match in the same cycle beats the write-1-to-clear.
    if (match_s) begin
      pend_d = 1'b1;
    end else if (wr_ctrl_s && csr_wdata[3]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (wr_ctrl_s) begin
      en_d   = csr_wdata[0];
      ie_d   = csr_wdata[1];
      auto_d = csr_wdata[2];
    end else begin
      en_d   = en_q;
      ie_d   = ie_q;
      auto_d = auto_q;
    end

    if (wr_cmp_s) begin
      cmp_d = csr_wdata;
    end else begin
      cmp_d = cmp_q;
    end

    if (wr_psc_s) begin
      prescale_d = csr_wdata[PRESCALE_WIDTH-1:0];
    end else begin
      prescale_d = prescale_q;
    end

    if (hit_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 32'd0;
    end
    valid_d = hit_s;

    // Registering PEND & IE next-state keeps irq_timer aligned with PEND.
    irq_d = pend_d & ie_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      auto_q     <= 1'b0;
      pend_q     <= 1'b0;
      count_q    <= 32'd0;
      cmp_q      <= RESET_CMP;
      prescale_q <= '0;
      psc_q      <= '0;
      rdata_q    <= 32'd0;
      valid_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      auto_q     <= auto_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      irq_q      <= irq_d;
    end
  end

  assign csr_rdata = rdata_q;
  assign csr_valid = valid_q;
  assign irq_timer = irq_q;

endmodule
